// File: rtl/blinky_pkg.sv
// Shared types and constants for the blinky control path and the LED rotator.
package blinky_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} dbnc_state_e;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;
endpackage

// File: rtl/blinky_ctrl_button_debounce.sv
// Button synchroniser plus debounce FSM; emits the clean level and a
// one-cycle press pulse aligned with the edge that sets the clean level.
module button_debounce
   import blinky_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_btn_clean,
   output logic o_press_pulse
);
   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam bit                SINGLE   = (DEBOUNCE_CYCLES == 1);

   logic             r_sync1, r_sync2;
   dbnc_state_e      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_clean, w_clean_nxt;
   logic             w_press;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_clean <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_clean <= w_clean_nxt;
      end
   end

   // A single-sample filter accepts straight from IDLE/HELD, skipping the check states.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clean_nxt = r_clean;
      w_press     = 1'b0;
      case (r_state)
         IDLE: if (r_sync2) begin
            if (SINGLE) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
               w_clean_nxt = 1'b1;
               w_press     = 1'b1;
            end else begin
               w_state_nxt = PRESS_CHK;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         PRESS_CHK: begin
            if (!r_sync2) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
               w_clean_nxt = 1'b1;
               w_press     = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         HELD: if (!r_sync2) begin
            if (SINGLE) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_clean_nxt = 1'b0;
            end else begin
               w_state_nxt = REL_CHK;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         REL_CHK: begin
            if (r_sync2) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_clean_nxt = 1'b0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_btn_clean   = r_clean;
   assign o_press_pulse = w_press;
endmodule

// File: rtl/blinky_ctrl.sv
// Direction toggle and step prescaler feeding the LED rotator.
// Optional BLINKY_SPEED_SEL_EN adds the 2-bit speed input dividing the step period.
module blinky_ctrl
   import blinky_pkg::*;
#(
   parameter int CLK_HZ          = 100_000_000,
   parameter int STEP_HZ         = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_dir,
   input  logic       run,
`ifdef BLINKY_SPEED_SEL_EN
   input  logic [1:0] speed,
`endif
   output logic       direction,
   output logic       step,
   output logic       btn_clean
);
   localparam int TICK_DIV = CLK_HZ / STEP_HZ;
   localparam int PW       = $clog2(TICK_DIV);

   logic          w_press;
   logic [PW-1:0] w_last;
   logic [PW-1:0] r_cnt;
   logic          r_dir, r_step;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
      .i_clk         (clk),
      .i_rst_n       (reset_n),
      .i_btn         (btn_dir),
      .o_btn_clean   (btn_clean),
      .o_press_pulse (w_press)
   );

`ifdef BLINKY_SPEED_SEL_EN
   logic [31:0] w_term;
   always_comb begin
      w_term = 32'(TICK_DIV) >> speed;
      if (w_term < 32'd2) w_term = 32'd2;
      w_last = PW'(w_term - 32'd1);
   end
`else
   assign w_last = PW'(TICK_DIV - 1);
`endif

   // '>=' lets a speed change that shrinks the period below the count wrap next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dir  <= DIR_LEFT;
         r_step <= 1'b0;
         r_cnt  <= '0;
      end else begin
         if (w_press) r_dir <= ~r_dir;
         if (run) begin
            if (r_cnt >= w_last) begin
               r_cnt  <= '0;
               r_step <= 1'b1;
            end else begin
               r_cnt  <= r_cnt + 1'b1;
               r_step <= 1'b0;
            end
         end else begin
            r_step <= 1'b0;
         end
      end
   end

   assign direction = r_dir;
   assign step      = r_step;
endmodule
